// File: rtl/register_file_sb.sv
// -----------------------------------------------------------------------------
// register_file_sb
//   Multi-read-port register file with asynchronous clear, write-to-read
//   bypass and a per-register busy scoreboard. The issue stage marks a
//   destination pending, writeback clears it, and decode stalls while a
//   source operand reports ReadBusy.
//
// Ports
//   clock      in   1                 rising-edge clock
//   reset_n    in   1                 asynchronous active-low clear
//   wr         in   1                 writeback enable
//   WriteAddr  in   Abits             writeback address
//   WriteData  in   Dbits             writeback data
//   issue      in   1                 mark IssueAddr pending
//   IssueAddr  in   Abits             destination being issued
//   ReadAddr   in   Nread*Abits       port k = [k*Abits +: Abits]
//   ReadData   out  Nread*Dbits       port k = [k*Dbits +: Dbits]
//   ReadBusy   out  Nread             port k operand still pending
//   BusyCount  out  $clog2(Nreg+1)    number of busy registers
// -----------------------------------------------------------------------------
module register_file_sb #(
  parameter  int Nreg     = 32,
  parameter  int Dbits    = 32,
  parameter  int Nread    = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int Abits    = $clog2(Nreg),
  localparam int Cbits    = $clog2(Nreg + 1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   wr,
  input  logic [Abits-1:0]       WriteAddr,
  input  logic [Dbits-1:0]       WriteData,
  input  logic                   issue,
  input  logic [Abits-1:0]       IssueAddr,
  input  logic [Nread*Abits-1:0] ReadAddr,
  output logic [Nread*Dbits-1:0] ReadData,
  output logic [Nread-1:0]       ReadBusy,
  output logic [Cbits-1:0]       BusyCount
);

  logic [Dbits-1:0] rf_q [Nreg];
  logic [Nreg-1:0]  busy_q, busy_d;
  logic [Cbits-1:0] cnt_q, cnt_d;
  logic             wr_en, iss_en, cnt_inc, cnt_dec;

  // Writes and issues aimed at a hardwired zero register are dropped.
  assign wr_en  = wr    && !((ZERO_REG != 0) && (WriteAddr == '0));
  assign iss_en = issue && !((ZERO_REG != 0) && (IssueAddr == '0));

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Nreg; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[WriteAddr] <= WriteData;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard. Clear first, then set: an issue to the address being
  // written back belongs to a newer producer and must stay pending.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (wr)     busy_d[WriteAddr] = 1'b0;
    if (iss_en) busy_d[IssueAddr] = 1'b1;
  end

  // The count tracks popcount(busy) incrementally: +1 only for a bit that
  // goes 0->1, -1 only for a bit that goes 1->0. Both may happen together
  // on different addresses, netting zero, so the counter cannot wrap.
  assign cnt_inc = iss_en && !busy_q[IssueAddr];
  assign cnt_dec = wr && busy_q[WriteAddr] && !(iss_en && (IssueAddr == WriteAddr));

  always_comb begin
    cnt_d = cnt_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign BusyCount = cnt_q;

  // ---------------------------------------------------------------------------
  // Combinational read ports
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < Nread; k++) begin : g_rd
    logic [Abits-1:0] rd_addr;
    logic             is_zero;
    logic             fwd_hit;

    assign rd_addr = ReadAddr[k*Abits +: Abits];
    assign is_zero = (ZERO_REG != 0) && (rd_addr == '0);
    // Same-cycle writeback to this operand: data is forwarded and the
    // operand is no longer considered pending.
    assign fwd_hit = (BYPASS != 0) && wr && (WriteAddr == rd_addr);

    // Outputs are forced low during reset, otherwise the bypass path could
    // leak WriteData while the array is held clear.
    assign ReadData[k*Dbits +: Dbits] = (!reset_n || is_zero) ? '0 :
                                        fwd_hit               ? WriteData :
                                                                rf_q[rd_addr];
    assign ReadBusy[k] = reset_n && !is_zero && busy_q[rd_addr] && !fwd_hit;
  end

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic        iss = 1'b0;
  logic [4:0]  ia = '0;
  logic [19:0] ra = '0;
  logic [9:0]  ra_b;

  logic [127:0] rd_a;
  logic [3:0]   rb_a;
  logic [5:0]   cnt_a;
  logic [63:0]  rd_b;
  logic [1:0]   rb_b;
  logic [5:0]   cnt_b;

  int checks = 0;
  int failures = 0;

  assign ra_b = ra[9:0];

  always #5 clk = ~clk;

  // A: 4 read ports, bypass on, zero register on.
  register_file_sb #(.Nreg(32), .Dbits(32), .Nread(4), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clock(clk), .reset_n(rst_n), .wr(wr), .WriteAddr(wa), .WriteData(wd),
    .issue(iss), .IssueAddr(ia), .ReadAddr(ra),
    .ReadData(rd_a), .ReadBusy(rb_a), .BusyCount(cnt_a));

  // B: 2 read ports, bypass off, zero register off.
  register_file_sb #(.Nreg(32), .Dbits(32), .Nread(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clock(clk), .reset_n(rst_n), .wr(wr), .WriteAddr(wa), .WriteData(wd),
    .issue(iss), .IssueAddr(ia), .ReadAddr(ra_b),
    .ReadData(rd_b), .ReadBusy(rb_b), .BusyCount(cnt_b));

  // Directed expectations: {dataA, busyA, cntA, dataB, busyB, cntB} for one port.
  logic [77:0]  dq[$];
  // Stress expectations: every output of both instances.
  logic [209:0] sq[$];

  // Reference model, index 0 = config A, 1 = config B.
  logic [31:0] m_rf   [2][32];
  bit          m_busy [2][32];
  bit          c_byp  [2] = '{1'b1, 1'b0};
  bit          c_zero [2] = '{1'b1, 1'b0};

  function automatic logic [77:0] obs(int k);
    return {rd_a[k*32 +: 32], rb_a[k], cnt_a, rd_b[k*32 +: 32], rb_b[k], cnt_b};
  endfunction

  function automatic logic [31:0] m_rd(int c, logic [4:0] a);
    if (c_zero[c] && a == 5'd0) return 32'd0;
    if (c_byp[c] && wr && wa == a) return wd;
    return m_rf[c][a];
  endfunction

  function automatic logic m_rb(int c, logic [4:0] a);
    if (c_zero[c] && a == 5'd0) return 1'b0;
    return m_busy[c][a] && !(c_byp[c] && wr && wa == a);
  endfunction

  function automatic logic [5:0] m_cnt(int c);
    logic [5:0] n = '0;
    for (int i = 0; i < 32; i++) n += {5'd0, m_busy[c][i]};
    return n;
  endfunction

  function automatic logic [209:0] m_expect();
    logic [127:0] da;
    logic [3:0]   ba;
    logic [63:0]  db;
    logic [1:0]   bb;
    for (int k = 0; k < 4; k++) begin
      da[k*32 +: 32] = m_rd(0, ra[k*5 +: 5]);
      ba[k]          = m_rb(0, ra[k*5 +: 5]);
    end
    for (int k = 0; k < 2; k++) begin
      db[k*32 +: 32] = m_rd(1, ra[k*5 +: 5]);
      bb[k]          = m_rb(1, ra[k*5 +: 5]);
    end
    return {da, ba, m_cnt(0), db, bb, m_cnt(1)};
  endfunction

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (wr && !(c_zero[c] && wa == 5'd0)) m_rf[c][wa] = wd;
      if (wr) m_busy[c][wa] = 1'b0;
      if (iss && !(c_zero[c] && ia == 5'd0)) m_busy[c][ia] = 1'b1;
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin
        m_rf[c][i]   = '0;
        m_busy[c][i] = 1'b0;
      end
  endtask

  task automatic drive(input logic w, input logic [4:0] wadr, input logic [31:0] wdat,
                       input logic i, input logic [4:0] iadr, input logic [19:0] radr);
    wr = w; wa = wadr; wd = wdat; iss = i; ia = iadr; ra = radr;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 20'd0);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [77:0] e;
    reset_dut();
    dq.push_back({32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(0) !== e) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs(0), e); end
    next_cycle();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 20'd5);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 20'd5);
    dq.push_back({32'hDEADBEEF, 1'b1, 6'd1, 32'hDEADBEEF, 1'b1, 6'd1});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(0) !== e) begin failures++; $display("FAIL reset_load got=%h exp=%h", obs(0), e); end
    // Reset pulsed between edges must clear everything at once.
    #1 rst_n = 1'b0;
    dq.push_back({32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0});
    #1;
    e = dq.pop_front(); checks++;
    if (obs(0) !== e) begin failures++; $display("FAIL reset_async got=%h exp=%h", obs(0), e); end
    #1 rst_n = 1'b1;
    dq.push_back({32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(0) !== e) begin failures++; $display("FAIL reset_after got=%h exp=%h", obs(0), e); end
  endtask

  task automatic test_zero_reg();
    logic [77:0] e;
    reset_dut();
    drive(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 20'd0);
    // A: hardwired zero. B: no bypass, so still old value pre-edge.
    dq.push_back({32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(0) !== e) begin failures++; $display("FAIL zero_pre got=%h exp=%h", obs(0), e); end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 20'd0);
    dq.push_back({32'd0, 1'b0, 6'd0, 32'h1234, 1'b1, 6'd1});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(0) !== e) begin failures++; $display("FAIL zero_post got=%h exp=%h", obs(0), e); end
  endtask

  task automatic test_bypass();
    logic [77:0] e;
    reset_dut();
    drive(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 20'd7);
    next_cycle();
    drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 20'd7);
    dq.push_back({32'hA5A5A5A5, 1'b0, 6'd0, 32'h11111111, 1'b0, 6'd0});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(0) !== e) begin failures++; $display("FAIL bypass_pre got=%h exp=%h", obs(0), e); end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 20'd7);
    dq.push_back({32'hA5A5A5A5, 1'b0, 6'd0, 32'hA5A5A5A5, 1'b0, 6'd0});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(0) !== e) begin failures++; $display("FAIL bypass_post got=%h exp=%h", obs(0), e); end
  endtask

  task automatic test_scoreboard();
    logic [77:0] e;
    reset_dut();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, {10'd0, 5'd3, 5'd0});
    dq.push_back({32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(1) !== e) begin failures++; $display("FAIL sb_issue_pre got=%h exp=%h", obs(1), e); end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd3, 5'd0});
    dq.push_back({32'd0, 1'b1, 6'd1, 32'd0, 1'b1, 6'd1});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(1) !== e) begin failures++; $display("FAIL sb_busy got=%h exp=%h", obs(1), e); end
    next_cycle();
    drive(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, {10'd0, 5'd3, 5'd0});
    dq.push_back({32'h55, 1'b0, 6'd1, 32'd0, 1'b1, 6'd1});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(1) !== e) begin failures++; $display("FAIL sb_wb_pre got=%h exp=%h", obs(1), e); end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd3, 5'd0});
    dq.push_back({32'h55, 1'b0, 6'd0, 32'h55, 1'b0, 6'd0});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(1) !== e) begin failures++; $display("FAIL sb_wb_post got=%h exp=%h", obs(1), e); end
  endtask

  task automatic test_simultaneous();
    logic [77:0] e;
    reset_dut();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 20'd9);
    next_cycle();
    // Issue and writeback to r9 together: data lands, busy re-set, count steady.
    drive(1'b1, 5'd9, 32'h77, 1'b1, 5'd9, 20'd9);
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 20'd9);   // WAW re-issue
    dq.push_back({32'h77, 1'b1, 6'd1, 32'h77, 1'b1, 6'd1});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(0) !== e) begin failures++; $display("FAIL simul_same got=%h exp=%h", obs(0), e); end
    next_cycle();
    // Clear r9 while setting r10: net count change zero.
    drive(1'b1, 5'd9, 32'h88, 1'b1, 5'd10, {10'd0, 5'd10, 5'd9});
    dq.push_back({32'h88, 1'b0, 6'd1, 32'h77, 1'b1, 6'd1});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(0) !== e) begin failures++; $display("FAIL simul_swap_pre got=%h exp=%h", obs(0), e); end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {10'd0, 5'd10, 5'd9});
    dq.push_back({32'd0, 1'b1, 6'd1, 32'd0, 1'b1, 6'd1});
    @(negedge clk);
    e = dq.pop_front(); checks++;
    if (obs(1) !== e) begin failures++; $display("FAIL simul_swap_r10 got=%h exp=%h", obs(1), e); end
  endtask

  task automatic test_stress();
    logic [209:0] e;
    logic [209:0] act;
    logic [19:0]  r;
    int           shown = 0;
    reset_dut();
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < 4; k++) r[k*5 +: 5] = 5'($urandom_range(0, 11));
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 11)), r);
      if (n % 500 == 250) begin
        wa = 5'($urandom); ia = 5'($urandom);
      end
      sq.push_back(m_expect());
      @(negedge clk);
      e   = sq.pop_front();
      act = {rd_a, rb_a, cnt_a, rd_b, rb_b, cnt_b};
      checks++;
      if (act !== e) begin
        failures++;
        if (shown < 10) $display("FAIL stress cyc=%0d got=%h exp=%h", n, act, e);
        shown++;
      end
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_stress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
